// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/MEM hazard inputs, debug
// controls, and pipeline enable/flush outputs with perf counters.
interface pipe_hazard_ctrl_if;
   logic [4:0]  rs1ID;
   logic [4:0]  rs2ID;
   logic        useRs1ID;
   logic        useRs2ID;
   logic [4:0]  rdEX;
   logic        lwEX;
   logic        jumpTakedMEM;
   logic        haltReq;
   logic        stepReq;
   logic        pcWrite;
   logic        ifIdWrite;
   logic        ifIdFlush;
   logic        idExFlush;
   logic        exMemFlush;
   logic        halted;
   logic [31:0] stallCount;
   logic [31:0] flushCount;

   modport master (
      output rs1ID, rs2ID, useRs1ID, useRs2ID, rdEX, lwEX,
      output jumpTakedMEM, haltReq, stepReq,
      input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush,
      input  halted, stallCount, flushCount
   );

   modport slave (
      input  rs1ID, rs2ID, useRs1ID, useRs2ID, rdEX, lwEX,
      input  jumpTakedMEM, haltReq, stepReq,
      output pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush,
      output halted, stallCount, flushCount
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, branch flush and debug halt/step control.
// Define PIPE_HAZARD_PERF_CNT_EN to build the stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int LOAD_STALL = 2
) (
   input logic               clock,
   input logic               reset,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {RUN, STALL, HALT, STEP} state_t;

   localparam logic [1:0] STALL_LOAD = 2'(LOAD_STALL - 1);
   localparam bit         MULTI      = (LOAD_STALL > 1);

   state_t     state;
   state_t     nextState;
   logic [1:0] cnt;
   logic [1:0] nextCnt;
   logic       toHalt;
   logic       nextToHalt;
   logic       haltedQ;
   logic       hazard;
   logic       flushHit;

   // Load-use hit between EX destination and ID sources
   always_comb begin
      hazard = hz.lwEX && (hz.rdEX != 5'd0) &&
               ((hz.useRs1ID && (hz.rs1ID == hz.rdEX)) ||
                (hz.useRs2ID && (hz.rs2ID == hz.rdEX)));
      flushHit = hz.jumpTakedMEM && (state != HALT);
   end

   // Next state: flush beats hazard, hazard beats halt
   always_comb begin
      nextState  = state;
      nextCnt    = cnt;
      nextToHalt = toHalt;
      unique case (state)
         RUN: begin
            if (flushHit) begin
               nextState = RUN;
            end else if (hazard) begin
               nextCnt    = STALL_LOAD;
               nextToHalt = 1'b0;
               if (MULTI) nextState = STALL;
            end else if (hz.haltReq) begin
               nextState = HALT;
            end
         end
         STALL: begin
            if (flushHit) begin
               nextState  = RUN;
               nextCnt    = 2'd0;
               nextToHalt = 1'b0;
            end else if (cnt <= 2'd1) begin
               nextState  = toHalt ? HALT : RUN;
               nextCnt    = 2'd0;
               nextToHalt = 1'b0;
            end else begin
               nextCnt = cnt - 2'd1;
            end
         end
         HALT: begin
            if (!hz.haltReq) nextState = RUN;
            else if (hz.stepReq) nextState = STEP;
         end
         STEP: begin
            nextState = HALT;
            if (!flushHit && hazard) begin
               nextCnt = STALL_LOAD;
               if (MULTI) begin
                  nextState  = STALL;
                  nextToHalt = 1'b1;
               end
            end
         end
         default: nextState = RUN;
      endcase
   end

   // State, stall down-counter and halted flag
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= RUN;
         cnt     <= 2'd0;
         toHalt  <= 1'b0;
         haltedQ <= 1'b0;
      end else begin
         state   <= nextState;
         cnt     <= nextCnt;
         toHalt  <= nextToHalt;
         haltedQ <= (nextState == HALT);
      end
   end

   // Pipeline enables and bubbles, combinational on state and inputs
   always_comb begin
      hz.pcWrite    = 1'b1;
      hz.ifIdWrite  = 1'b1;
      hz.ifIdFlush  = 1'b0;
      hz.idExFlush  = 1'b0;
      hz.exMemFlush = 1'b0;
      if (!reset) begin
         hz.pcWrite    = 1'b0;
         hz.ifIdWrite  = 1'b0;
         hz.ifIdFlush  = 1'b1;
         hz.idExFlush  = 1'b1;
         hz.exMemFlush = 1'b1;
      end else if (state == HALT) begin
         hz.pcWrite   = 1'b0;
         hz.ifIdWrite = 1'b0;
         hz.idExFlush = 1'b1;
      end else if (flushHit) begin
         hz.ifIdFlush  = 1'b1;
         hz.idExFlush  = 1'b1;
         hz.exMemFlush = 1'b1;
      end else if ((state == STALL) || hazard) begin
         hz.pcWrite   = 1'b0;
         hz.ifIdWrite = 1'b0;
         hz.idExFlush = 1'b1;
      end
   end

   assign hz.halted = haltedQ;

`ifdef PIPE_HAZARD_PERF_CNT_EN
   logic [31:0] stallCnt;
   logic [31:0] flushCnt;
   logic        stallHit;

   assign stallHit = (state != HALT) && !flushHit &&
                     ((state == STALL) || hazard);

   // Free-running wrap-around performance counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stallCnt <= 32'd0;
         flushCnt <= 32'd0;
      end else begin
         if (stallHit) stallCnt <= stallCnt + 32'd1;
         if (flushHit) flushCnt <= flushCnt + 32'd1;
      end
   end

   assign hz.stallCount = stallCnt;
   assign hz.flushCount = flushCnt;
`else
   assign hz.stallCount = 32'd0;
   assign hz.flushCount = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random
// traffic against a cycle-level reference of the control rules.
module tb_pipe_hazard_ctrl;

   localparam int LS = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl #(.LOAD_STALL(LS)) dut (
      .clock (clock),
      .reset (reset),
      .hz    (bus)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   bit          parked;
   bit          stepping;
   bit          backToHalt;
   int          stallLeft;
   logic [31:0] mStall;
   logic [31:0] mFlush;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cntExp(logic [31:0] v);
`ifdef PIPE_HAZARD_PERF_CNT_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   task automatic idle();
      bus.rs1ID        = 5'd0;
      bus.rs2ID        = 5'd0;
      bus.useRs1ID     = 1'b0;
      bus.useRs2ID     = 1'b0;
      bus.rdEX         = 5'd0;
      bus.lwEX         = 1'b0;
      bus.jumpTakedMEM = 1'b0;
      bus.stepReq      = 1'b0;
   endtask

   task automatic modelClear();
      parked     = 1'b0;
      stepping   = 1'b0;
      backToHalt = 1'b0;
      stallLeft  = 0;
      mStall     = 32'd0;
      mFlush     = 32'd0;
   endtask

   task automatic resetChk();
      chk("rst.pcWrite", 32'(bus.pcWrite), 32'd0);
      chk("rst.ifIdWrite", 32'(bus.ifIdWrite), 32'd0);
      chk("rst.ifIdFlush", 32'(bus.ifIdFlush), 32'd1);
      chk("rst.idExFlush", 32'(bus.idExFlush), 32'd1);
      chk("rst.exMemFlush", 32'(bus.exMemFlush), 32'd1);
      chk("rst.halted", 32'(bus.halted), 32'd0);
      chk("rst.stallCount", bus.stallCount, 32'd0);
      chk("rst.flushCount", bus.flushCount, 32'd0);
   endtask

   // Called just after a falling edge with inputs set; checks the
   // cycle, advances the reference, and returns at the next fall.
   task automatic tick();
      bit haz;
      bit eP;
      bit eIf;
      bit eId;
      bit eEm;
      #1;
      haz = bus.lwEX && (bus.rdEX != 0) &&
            ((bus.useRs1ID && bus.rs1ID == bus.rdEX) ||
             (bus.useRs2ID && bus.rs2ID == bus.rdEX));
      chk("halted", 32'(bus.halted), 32'(parked));
      chk("stallCount", bus.stallCount, cntExp(mStall));
      chk("flushCount", bus.flushCount, cntExp(mFlush));
      eP  = 1'b1;
      eIf = 1'b0;
      eId = 1'b0;
      eEm = 1'b0;
      if (parked) begin
         eP  = 1'b0;
         eId = 1'b1;
         if (!bus.haltReq) begin
            parked = 1'b0;
         end else if (bus.stepReq) begin
            parked   = 1'b0;
            stepping = 1'b1;
         end
      end else if (bus.jumpTakedMEM) begin
         eIf = 1'b1;
         eId = 1'b1;
         eEm = 1'b1;
         mFlush++;
         if (stepping) parked = 1'b1;
         stepping   = 1'b0;
         stallLeft  = 0;
         backToHalt = 1'b0;
      end else if (stallLeft > 0) begin
         eP  = 1'b0;
         eId = 1'b1;
         mStall++;
         stallLeft--;
         if (stallLeft == 0 && backToHalt) begin
            parked     = 1'b1;
            backToHalt = 1'b0;
         end
      end else if (haz) begin
         eP  = 1'b0;
         eId = 1'b1;
         mStall++;
         stallLeft = LS - 1;
         if (stepping) begin
            if (stallLeft > 0) backToHalt = 1'b1;
            else parked = 1'b1;
         end
         stepping = 1'b0;
      end else begin
         if (stepping || bus.haltReq) parked = 1'b1;
         stepping = 1'b0;
      end
      chk("pcWrite", 32'(bus.pcWrite), 32'(eP));
      chk("ifIdWrite", 32'(bus.ifIdWrite), 32'(eP));
      chk("ifIdFlush", 32'(bus.ifIdFlush), 32'(eIf));
      chk("idExFlush", 32'(bus.idExFlush), 32'(eId));
      chk("exMemFlush", 32'(bus.exMemFlush), 32'(eEm));
      @(negedge clock);
   endtask

   task automatic loadUse();
      bus.lwEX     = 1'b1;
      bus.rdEX     = 5'd5;
      bus.rs1ID    = 5'd5;
      bus.useRs1ID = 1'b1;
   endtask

   initial begin
      idle();
      bus.haltReq = 1'b0;
      modelClear();
      #1;
      resetChk();
      @(negedge clock);
      reset = 1'b1;
      tick();

      // load-use: two bubbles, then flow resumes
      loadUse();
      tick();
      tick();
      idle();
      tick();
      chk("ldUse.stallCount", bus.stallCount, cntExp(32'd2));

      // x0 destination and unused source never stall
      loadUse();
      bus.rdEX  = 5'd0;
      bus.rs1ID = 5'd0;
      tick();
      loadUse();
      bus.useRs1ID = 1'b0;
      tick();

      // branch in first stall cycle aborts the stall
      loadUse();
      tick();
      idle();
      bus.jumpTakedMEM = 1'b1;
      tick();
      idle();
      tick();

      // halt, single step, resume
      bus.haltReq = 1'b1;
      tick();
      tick();
      bus.stepReq = 1'b1;
      tick();
      bus.stepReq = 1'b0;
      tick();
      tick();
      bus.haltReq = 1'b0;
      tick();
      tick();

      // async reset between edges while halted
      bus.haltReq = 1'b1;
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      resetChk();
      @(negedge clock);
      bus.haltReq = 1'b0;
      reset = 1'b1;
      modelClear();
      tick();

`ifdef PIPE_HAZARD_PERF_CNT_EN
      force dut.stallCnt = 32'hFFFF_FFFF;
      #1;
      release dut.stallCnt;
      mStall = 32'hFFFF_FFFF;
      loadUse();
      tick();
      idle();
      tick();
      chk("wrap.stallCount", bus.stallCount, 32'd1);
`endif

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bus.rs1ID        = 5'($urandom_range(0, 3));
         bus.rs2ID        = 5'($urandom_range(0, 3));
         bus.rdEX         = 5'($urandom_range(0, 3));
         bus.useRs1ID     = 1'($urandom_range(0, 1));
         bus.useRs2ID     = 1'($urandom_range(0, 1));
         bus.lwEX         = 1'($urandom_range(0, 1));
         bus.jumpTakedMEM = ($urandom_range(0, 7) == 0);
         bus.stepReq      = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) bus.haltReq = ~bus.haltReq;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
